// File: rtl/control_unit_pkg.sv
// control_unit_pkg: bit indices, opcodes, state encoding and helpers for the T-state sequencer
package control_unit_pkg;
  localparam int OP_W = 5;
  localparam int DIV_CYCLES_DEF = 34;
  localparam int DP_PC = 0;
  localparam int DP_IR = 1;
  localparam int DP_Y = 2;
  localparam int DP_MAR = 3;
  localparam int DP_MDR = 4;
  localparam int DP_INPORT = 5;
  localparam int DP_OUTPORT = 6;
  localparam int DP_Z = 7;
  localparam int DP_ZHI = 8;
  localparam int DP_ZLO = 9;
  localparam int DP_HI = 10;
  localparam int DP_LO = 11;
  localparam int DP_READ = 12;
  localparam int DP_C = 13;
  localparam int A_ADD = 0;
  localparam int A_SUB = 1;
  localparam int A_NEG = 2;
  localparam int A_MUL = 3;
  localparam int A_DIV = 4;
  localparam int A_AND = 5;
  localparam int A_OR = 6;
  localparam int A_ROR = 7;
  localparam int A_ROL = 8;
  localparam int A_SLL = 9;
  localparam int A_SRA = 10;
  localparam int A_SRL = 11;
  localparam int A_NOT = 12;
  localparam int A_INC = 13;
  localparam logic [OP_W-1:0] OP_LD = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI = 5'd1;
  localparam logic [OP_W-1:0] OP_ST = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB = 5'd4;
  localparam logic [OP_W-1:0] OP_AND = 5'd5;
  localparam logic [OP_W-1:0] OP_OR = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR = 5'd9;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV = 5'd15;
  localparam logic [OP_W-1:0] OP_MUL = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT = 5'd18;
  localparam logic [OP_W-1:0] OP_BR = 5'd19;
  localparam logic [OP_W-1:0] OP_JAL = 5'd20;
  localparam logic [OP_W-1:0] OP_JR = 5'd21;
  localparam logic [OP_W-1:0] OP_IN = 5'd22;
  localparam logic [OP_W-1:0] OP_OUT = 5'd23;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd24;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd25;
  localparam logic [OP_W-1:0] OP_NOP = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef struct packed {
    logic [15:0] dpin;
    logic [15:0] dpout;
    logic [15:0] alu;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic ram_wr;
    logic conin;
  } ctrl_t;
  function automatic logic [15:0] alu_sel(input logic [OP_W-1:0] op);
    logic [15:0] a;
    a = '0;
    case (op)
      OP_ADD, OP_ADDI: a[A_ADD] = 1'b1;
      OP_SUB: a[A_SUB] = 1'b1;
      OP_AND, OP_ANDI: a[A_AND] = 1'b1;
      OP_OR, OP_ORI: a[A_OR] = 1'b1;
      OP_ROR: a[A_ROR] = 1'b1;
      OP_ROL: a[A_ROL] = 1'b1;
      OP_SHR: a[A_SRL] = 1'b1;
      OP_SHRA: a[A_SRA] = 1'b1;
      OP_SHL: a[A_SLL] = 1'b1;
      OP_MUL: a[A_MUL] = 1'b1;
      OP_DIV: a[A_DIV] = 1'b1;
      OP_NEG: a[A_NEG] = 1'b1;
      OP_NOT: a[A_NOT] = 1'b1;
      default: a = '0;
    endcase
    return a;
  endfunction
  // final T-state of each instruction; br length depends on the branch flag
  function automatic state_t last_state(input logic [OP_W-1:0] op, input logic con);
    case (op)
      OP_LD, OP_ST: return T7;
      OP_MUL, OP_DIV: return T6;
      OP_BR: return con ? T6 : T4;
      OP_NEG, OP_NOT, OP_JAL: return T4;
      default: return (op >= OP_LDI && op <= OP_ORI) ? T5 : T3;
    endcase
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: sequencer <-> datapath control bundle
// master (sequencer): in ir_op, CON; out DPin, DPout, ALUopp, Gra..CONin strobes, run
// slave (datapath):   mirror of master
interface control_unit_if;
  import control_unit_pkg::*;
  logic [OP_W-1:0] ir_op;
  logic CON;
  logic [15:0] DPin;
  logic [15:0] DPout;
  logic [15:0] ALUopp;
  logic Gra;
  logic Grb;
  logic Grc;
  logic Rin;
  logic Rout;
  logic BAout;
  logic RAM_wr;
  logic CONin;
  logic run;
  modport master (
    input ir_op, CON,
    output DPin, DPout, ALUopp, Gra, Grb, Grc, Rin, Rout, BAout, RAM_wr, CONin, run
  );
  modport slave (
    output ir_op, CON,
    input DPin, DPout, ALUopp, Gra, Grb, Grc, Rin, Rout, BAout, RAM_wr, CONin, run
  );
endinterface

// File: rtl/control_unit_decode.sv
// control_unit_decode: combinational (state, opcode, CON) -> full datapath control vector
// ports: st state, op effective opcode, con branch flag, c control vector
module control_unit_decode
  import control_unit_pkg::*;
(
  input state_t st,
  input logic [OP_W-1:0] op,
  input logic con,
  output ctrl_t c
);
  logic imm;
  assign imm = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
  always_comb begin
    c = '0;
    case (st)
      T0: begin c.dpout[DP_PC] = 1'b1; c.dpin[DP_MAR] = 1'b1; c.dpin[DP_Z] = 1'b1; c.alu[A_INC] = 1'b1; end
      T1: begin c.dpout[DP_ZLO] = 1'b1; c.dpin[DP_PC] = 1'b1; c.dpin[DP_MDR] = 1'b1; c.dpin[DP_READ] = 1'b1; end
      T2: begin c.dpout[DP_MDR] = 1'b1; c.dpin[DP_IR] = 1'b1; end
      RST, HALT: c = '0;
      default:
        case (op)
          OP_LD, OP_LDI, OP_ST:
            case (st)
              T3: begin c.grb = 1'b1; c.baout = 1'b1; c.dpin[DP_Y] = 1'b1; end
              T4: begin c.dpout[DP_C] = 1'b1; c.alu[A_ADD] = 1'b1; c.dpin[DP_Z] = 1'b1; end
              T5: begin
                c.dpout[DP_ZLO] = 1'b1;
                c.gra = op == OP_LDI;
                c.rin = op == OP_LDI;
                c.dpin[DP_MAR] = op != OP_LDI;
              end
              T6: begin
                c.dpin[DP_MDR] = 1'b1;
                c.gra = op == OP_ST;
                c.rout = op == OP_ST;
                c.dpin[DP_READ] = op != OP_ST;
              end
              T7: begin
                c.ram_wr = op == OP_ST;
                c.dpout[DP_MDR] = op != OP_ST;
                c.gra = op != OP_ST;
                c.rin = op != OP_ST;
              end
              default: c = '0;
            endcase
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:
            case (st)
              T3: begin c.grb = 1'b1; c.rout = 1'b1; c.dpin[DP_Y] = 1'b1; end
              T4: begin
                c.dpout[DP_C] = imm;
                c.grc = !imm;
                c.rout = !imm;
                c.alu = alu_sel(op);
                c.dpin[DP_Z] = 1'b1;
              end
              T5: begin c.dpout[DP_ZLO] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              default: c = '0;
            endcase
          OP_MUL, OP_DIV:
            case (st)
              T3: begin c.gra = 1'b1; c.rout = 1'b1; c.dpin[DP_Y] = 1'b1; end
              T4: begin c.grb = 1'b1; c.rout = 1'b1; c.alu = alu_sel(op); c.dpin[DP_Z] = 1'b1; end
              T5: begin c.dpout[DP_ZLO] = 1'b1; c.dpin[DP_LO] = 1'b1; end
              T6: begin c.dpout[DP_ZHI] = 1'b1; c.dpin[DP_HI] = 1'b1; end
              default: c = '0;
            endcase
          OP_NEG, OP_NOT:
            case (st)
              T3: begin c.grb = 1'b1; c.rout = 1'b1; c.alu = alu_sel(op); c.dpin[DP_Z] = 1'b1; end
              T4: begin c.dpout[DP_ZLO] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
              default: c = '0;
            endcase
          OP_BR:
            case (st)
              T3: begin c.gra = 1'b1; c.rout = 1'b1; c.conin = 1'b1; end
              T4: begin c.dpout[DP_PC] = con; c.dpin[DP_Y] = con; end
              T5: begin c.dpout[DP_C] = 1'b1; c.alu[A_ADD] = 1'b1; c.dpin[DP_Z] = 1'b1; end
              T6: begin c.dpout[DP_ZLO] = 1'b1; c.dpin[DP_PC] = 1'b1; end
              default: c = '0;
            endcase
          OP_JAL:
            case (st)
              T3: begin c.dpout[DP_PC] = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
              T4: begin c.gra = 1'b1; c.rout = 1'b1; c.dpin[DP_PC] = 1'b1; end
              default: c = '0;
            endcase
          OP_JR: if (st == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.dpin[DP_PC] = 1'b1; end
          OP_IN: if (st == T3) begin c.dpout[DP_INPORT] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_OUT: if (st == T3) begin c.gra = 1'b1; c.rout = 1'b1; c.dpin[DP_OUTPORT] = 1'b1; end
          OP_MFLO: if (st == T3) begin c.dpout[DP_LO] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          OP_MFHI: if (st == T3) begin c.dpout[DP_HI] = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: c = '0;
        endcase
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired T-state sequencer driving all datapath control inputs
// ports: clk, clr (async active-high reset), step (only with CONTROL_STEP_EN), bus (control_unit_if.master)
// CONTROL_STEP_EN: when defined, state advances only on edges with step=1 and outputs are 0 while step=0
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic clk,
  input logic clr,
`ifdef CONTROL_STEP_EN
  input logic step,
`endif
  control_unit_if.master bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  state_t st, nxt;
  logic [OP_W-1:0] op_q, op;
  logic [CW-1:0] cnt;
  logic adv;
  ctrl_t c, g;
`ifdef CONTROL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  // IR is loaded at the end of T2, so T3 decodes the live opcode and later states the latched copy
  assign op = (st == T3) ? bus.ir_op : op_q;
  always_comb begin
    nxt = st;
    case (st)
      RST: nxt = T0;
      HALT: nxt = HALT;
      T0, T1, T2: nxt = state_t'(st + 4'd1);
      default:
        nxt = (st == T3 && op == OP_HALT) ? HALT :
              (st == T4 && op == OP_DIV && cnt != '0) ? T4 :
              (st >= last_state(op, bus.CON)) ? T0 : state_t'(st + 4'd1);
    endcase
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st <= RST;
      op_q <= '0;
      cnt <= '0;
    end else if (adv) begin
      st <= nxt;
      if (st == T3) begin
        op_q <= bus.ir_op;
        cnt <= CW'(DIV_CYCLES - 1);
      end else if (st == T4 && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  control_unit_decode u_decode (.st(st), .op(op), .con(bus.CON), .c(c));
  assign g = adv ? c : '0;
  assign bus.DPin = g.dpin;
  assign bus.DPout = g.dpout;
  assign bus.ALUopp = g.alu;
  assign bus.Gra = g.gra;
  assign bus.Grb = g.grb;
  assign bus.Grc = g.grc;
  assign bus.Rin = g.rin;
  assign bus.Rout = g.rout;
  assign bus.BAout = g.baout;
  assign bus.RAM_wr = g.ram_wr;
  assign bus.CONin = g.conin;
  assign bus.run = st != RST && st != HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven per-cycle check of the control sequencer plus reset/halt/step sequences
module tb_control_unit;
  localparam logic [7:0] GRA = 8'h80;
  localparam logic [7:0] GRB = 8'h40;
  localparam logic [7:0] GRC = 8'h20;
  localparam logic [7:0] RIN = 8'h10;
  localparam logic [7:0] ROUT = 8'h08;
  localparam logic [7:0] BAOUT = 8'h04;
  localparam logic [7:0] RAMWR = 8'h02;
  localparam logic [7:0] CONIN = 8'h01;
  typedef struct {
    logic [4:0] op;
    logic con;
    logic [15:0] dpin;
    logic [15:0] dpout;
    logic [15:0] alu;
    logic [7:0] fl;
  } vec_t;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  control_unit_if bus();
`ifdef CONTROL_STEP_EN
  logic step = 1'b1;
`endif
  control_unit dut (
    .clk(clk),
    .clr(clr),
`ifdef CONTROL_STEP_EN
    .step(step),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [56:0] obs();
    return {bus.run, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.RAM_wr, bus.CONin,
            bus.ALUopp, bus.DPout, bus.DPin};
  endfunction
  task automatic chk(input string name, input logic [56:0] act, input logic [56:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic p(input logic [4:0] op, input logic con, input logic [15:0] dpin, input logic [15:0] dpout,
                   input logic [15:0] alu, input logic [7:0] fl);
    vec_t v;
    v.op = op; v.con = con; v.dpin = dpin; v.dpout = dpout; v.alu = alu; v.fl = fl;
    tbl.push_back(v);
  endtask
  task automatic f(input logic [4:0] op, input logic con);
    p(op, con, 16'h0088, 16'h0001, 16'h2000, 8'h00);
    p(op, con, 16'h1011, 16'h0200, 16'h0000, 8'h00);
    p(op, con, 16'h0002, 16'h0010, 16'h0000, 8'h00);
  endtask
  task automatic ld_head(input logic [4:0] op);
    f(op, 1'b0);
    p(op, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRB | BAOUT);
    p(op, 1'b0, 16'h0080, 16'h2000, 16'h0001, 8'h00);
  endtask
  initial begin
    int bad;
    int n;
    f(5'd3, 1'b0);
    p(5'd3, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRB | ROUT);
    p(5'd3, 1'b0, 16'h0080, 16'h0000, 16'h0001, GRC | ROUT);
    p(5'd3, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd13, 1'b0);
    p(5'd13, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRB | ROUT);
    p(5'd13, 1'b0, 16'h0080, 16'h2000, 16'h0020, 8'h00);
    p(5'd13, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd10, 1'b0);
    p(5'd10, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRB | ROUT);
    p(5'd10, 1'b0, 16'h0080, 16'h0000, 16'h0400, GRC | ROUT);
    p(5'd10, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd17, 1'b0);
    p(5'd17, 1'b0, 16'h0080, 16'h0000, 16'h0004, GRB | ROUT);
    p(5'd17, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd18, 1'b0);
    p(5'd18, 1'b0, 16'h0080, 16'h0000, 16'h1000, GRB | ROUT);
    p(5'd18, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd19, 1'b0);
    p(5'd19, 1'b0, 16'h0000, 16'h0000, 16'h0000, GRA | ROUT | CONIN);
    p(5'd19, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h00);
    f(5'd19, 1'b1);
    p(5'd19, 1'b1, 16'h0000, 16'h0000, 16'h0000, GRA | ROUT | CONIN);
    p(5'd19, 1'b1, 16'h0004, 16'h0001, 16'h0000, 8'h00);
    p(5'd19, 1'b1, 16'h0080, 16'h2000, 16'h0001, 8'h00);
    p(5'd19, 1'b1, 16'h0001, 16'h0200, 16'h0000, 8'h00);
    ld_head(5'd0);
    p(5'd0, 1'b0, 16'h0008, 16'h0200, 16'h0000, 8'h00);
    p(5'd0, 1'b0, 16'h1010, 16'h0000, 16'h0000, 8'h00);
    p(5'd0, 1'b0, 16'h0000, 16'h0010, 16'h0000, GRA | RIN);
    ld_head(5'd2);
    p(5'd2, 1'b0, 16'h0008, 16'h0200, 16'h0000, 8'h00);
    p(5'd2, 1'b0, 16'h0010, 16'h0000, 16'h0000, GRA | ROUT);
    p(5'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, RAMWR);
    ld_head(5'd1);
    p(5'd1, 1'b0, 16'h0000, 16'h0200, 16'h0000, GRA | RIN);
    f(5'd20, 1'b0);
    p(5'd20, 1'b0, 16'h0000, 16'h0001, 16'h0000, GRB | RIN);
    p(5'd20, 1'b0, 16'h0001, 16'h0000, 16'h0000, GRA | ROUT);
    f(5'd21, 1'b0);
    p(5'd21, 1'b0, 16'h0001, 16'h0000, 16'h0000, GRA | ROUT);
    f(5'd22, 1'b0);
    p(5'd22, 1'b0, 16'h0000, 16'h0020, 16'h0000, GRA | RIN);
    f(5'd23, 1'b0);
    p(5'd23, 1'b0, 16'h0040, 16'h0000, 16'h0000, GRA | ROUT);
    f(5'd24, 1'b0);
    p(5'd24, 1'b0, 16'h0000, 16'h0800, 16'h0000, GRA | RIN);
    f(5'd25, 1'b0);
    p(5'd25, 1'b0, 16'h0000, 16'h0400, 16'h0000, GRA | RIN);
    f(5'd26, 1'b0);
    p(5'd26, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h00);
    f(5'd30, 1'b0);
    p(5'd30, 1'b0, 16'h0000, 16'h0000, 16'h0000, 8'h00);
    f(5'd16, 1'b0);
    p(5'd16, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRA | ROUT);
    p(5'd16, 1'b0, 16'h0080, 16'h0000, 16'h0008, GRB | ROUT);
    p(5'd16, 1'b0, 16'h0800, 16'h0200, 16'h0000, 8'h00);
    p(5'd16, 1'b0, 16'h0400, 16'h0100, 16'h0000, 8'h00);
    f(5'd15, 1'b0);
    p(5'd15, 1'b0, 16'h0004, 16'h0000, 16'h0000, GRA | ROUT);
    for (int i = 0; i < 34; i++) p(5'd15, 1'b0, 16'h0080, 16'h0000, 16'h0010, GRB | ROUT);
    p(5'd15, 1'b0, 16'h0800, 16'h0200, 16'h0000, 8'h00);
    p(5'd15, 1'b0, 16'h0400, 16'h0100, 16'h0000, 8'h00);
    bus.ir_op = 5'd0;
    bus.CON = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset outputs", obs(), 57'd0);
    clr = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.ir_op = tbl[i].op;
      bus.CON = tbl[i].con;
      #1 chk($sformatf("vec%0d op%0d", i, tbl[i].op), obs(),
             {1'b1, tbl[i].fl, tbl[i].alu, tbl[i].dpout, tbl[i].dpin});
    end
    bus.ir_op = 5'd3;
    bus.CON = 1'b0;
    @(negedge clk);
    #1 chk("clr seq T0", obs(), {1'b1, 8'h00, 16'h2000, 16'h0001, 16'h0088});
    @(negedge clk);
    #1 chk("clr seq T1", obs(), {1'b1, 8'h00, 16'h0000, 16'h0200, 16'h1011});
    #1 clr = 1'b1;
    #1 chk("clr mid T1", obs(), 57'd0);
    @(negedge clk);
    #1 chk("clr held", obs(), 57'd0);
    clr = 1'b0;
    bus.ir_op = 5'd27;
    @(negedge clk);
    #1 chk("clr release T0", obs(), {1'b1, 8'h00, 16'h2000, 16'h0001, 16'h0088});
    repeat (2) @(negedge clk);
    @(negedge clk);
    #1 chk("halt T3", obs(), {1'b1, 56'd0});
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      #1 if (obs() !== 57'd0) bad++;
    end
    chk("halt idle cycles", 57'(bad), 57'd0);
`ifdef CONTROL_STEP_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.ir_op = 5'd15;
    repeat (5) @(negedge clk);
    #1 chk("step div T4", obs(), {1'b1, GRB | ROUT, 16'h0010, 16'h0000, 16'h0080});
    step = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1 chk("step frozen", obs(), {1'b1, 56'd0});
    end
    step = 1'b1;
    n = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1 if (bus.ALUopp !== 16'h0010) break;
      n++;
    end
    chk("step div T4 length", 57'(n), 57'd34);
    chk("step div T5", obs(), {1'b1, 8'h00, 16'h0000, 16'h0200, 16'h0800});
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
